boiler_fill_ctrl: RTL and testbench

//  Game-logic controller for one boiler sprite. Sequences player button pulses into

---
 rtl/boiler_fill_ctrl_pkg.sv | 39 +++
 rtl/boiler_fill_ctrl_pour_timer.sv | 49 ++++
 rtl/boiler_fill_ctrl.sv | 175 +++++++++++++++++
 tb/tb_boiler_fill_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/boiler_fill_ctrl_pkg.sv
// Shared definitions for the boiler sprite controllers.
//   - colour codes driven to the renderer (0 = empty/white, 1..6 paint colours)
//   - FSM state encodings for the fill controller
//   - layer count of one boiler and a helper that cycles the pending colour
package boiler_fill_ctrl_pkg;

   localparam logic [2:0] COL_EMPTY      = 3'd0;
   localparam logic [2:0] COL_PINK       = 3'd1;
   localparam logic [2:0] COL_LIGHTGREEN = 3'd2;
   localparam logic [2:0] COL_ORANGE     = 3'd3;
   localparam logic [2:0] COL_BLUE       = 3'd4;
   localparam logic [2:0] COL_LIGHTBLUE  = 3'd5;
   localparam logic [2:0] COL_LIGHTGREY  = 3'd6;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_SELECTED  = 2'd1;
   localparam logic [1:0] ST_POURING   = 2'd2;
   localparam logic [1:0] ST_CONFIRMED = 2'd3;

   localparam int         MAX_LAYERS = 4;
   localparam logic [2:0] LEVEL_FULL = 3'(MAX_LAYERS);

   // Pending colour walks 1..6 and wraps; code 7 (and 0) fall back to pink
   // so an illegal value can never be poured.
   function automatic logic [2:0] next_colour(input logic [2:0] c);
      logic [2:0] n;
      case (c)
         COL_PINK:       n = COL_LIGHTGREEN;
         COL_LIGHTGREEN: n = COL_ORANGE;
         COL_ORANGE:     n = COL_BLUE;
         COL_BLUE:       n = COL_LIGHTBLUE;
         COL_LIGHTBLUE:  n = COL_LIGHTGREY;
         COL_LIGHTGREY:  n = COL_PINK;
         default:        n = COL_PINK;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/boiler_fill_ctrl_pour_timer.sv
// pour_timer: counts frame_tick pulses while a pour animation runs.
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   start_i       clears the count as a new pour begins
//   run_i         high while the controller is pouring; ticks count only then
//   frame_tick_i  1-cycle pulse per display frame
//   done_o        combinational; high on the tick that completes FILL_TICKS
module pour_timer #(
   parameter int FILL_TICKS = 30
) (
   input  logic clk,
   input  logic reset,
   input  logic start_i,
   input  logic run_i,
   input  logic frame_tick_i,
   output logic done_o
);

   localparam int             CW   = $clog2(FILL_TICKS + 1);
   localparam logic [CW-1:0]  LAST = CW'(FILL_TICKS - 1);

   logic [CW-1:0] tick_cnt_q;
   logic [CW-1:0] tick_cnt_d;
   logic          count_en;

   assign count_en = run_i && frame_tick_i;

   // The tick that would bring the count to FILL_TICKS finishes the pour and
   // returns the count to zero, so the register never holds FILL_TICKS.
   assign done_o = count_en && (tick_cnt_q == LAST);

   always_comb begin
      tick_cnt_d = tick_cnt_q;
      if (start_i || done_o) begin
         tick_cnt_d = '0;
      end else if (count_en) begin
         tick_cnt_d = tick_cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tick_cnt_q <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
      end
   end

endmodule

// File: rtl/boiler_fill_ctrl.sv
// boiler_fill_ctrl: game-logic controller for one boiler sprite. Turns button
// pulses into layer-by-layer colour fills with a timed pour, undo and confirm.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   frame_tick          1-cycle pulse per display frame (pour animation pacing)
//   btn_sel/next/pour/undo/confirm  1-cycle debounced button pulses
//   pending_colour      colour the next pour will write (1..6)
//   colour1..colour4    layer colours to the renderer, colour1 = bottom, 0 = empty
//   fill_level          filled layers, 0..4
//   selected/confirmed/busy  registered state decodes
//   pour_done           1-cycle pulse in the cycle a layer is written
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | not selected; only btn_sel is honoured
// SELECTED   | player editing: sel > confirm > undo > pour > next
// POURING    | pour animation running, buttons ignored until timer done
// CONFIRMED  | boiler locked; btn_sel clears it and returns to IDLE
module boiler_fill_ctrl
   import boiler_fill_ctrl_pkg::*;
#(
   parameter int FILL_TICKS = 30
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       btn_sel,
   input  logic       btn_next,
   input  logic       btn_pour,
   input  logic       btn_undo,
   input  logic       btn_confirm,
   output logic [2:0] pending_colour,
   output logic [2:0] colour1,
   output logic [2:0] colour2,
   output logic [2:0] colour3,
   output logic [2:0] colour4,
   output logic [2:0] fill_level,
   output logic       selected,
   output logic       confirmed,
   output logic       busy,
   output logic       pour_done
);

   logic [1:0] state_q, state_d;
   logic [2:0] fill_q, fill_d;
   logic [2:0] pend_q, pend_d;
   logic [2:0] layer_q [MAX_LAYERS];
   logic [2:0] layer_d [MAX_LAYERS];
   logic       selected_q, confirmed_q, busy_q, pour_done_q;
   logic       pour_start;
   logic       timer_done;
   logic [1:0] top_idx;
   logic [1:0] next_idx;

   // top_idx addresses the topmost filled layer (only used when fill_q > 0),
   // next_idx the first empty one (only used when fill_q < 4).
   assign top_idx  = 2'(fill_q - 3'd1);
   assign next_idx = fill_q[1:0];

   pour_timer #(
      .FILL_TICKS (FILL_TICKS)
   ) u_pour_timer (
      .clk          (clk),
      .reset        (reset),
      .start_i      (pour_start),
      .run_i        (state_q == ST_POURING),
      .frame_tick_i (frame_tick),
      .done_o       (timer_done)
   );

   always_comb begin
      state_d    = state_q;
      fill_d     = fill_q;
      pend_d     = pend_q;
      pour_start = 1'b0;
      for (int i = 0; i < MAX_LAYERS; i++) begin
         layer_d[i] = layer_q[i];
      end

      case (state_q)
         ST_IDLE: begin
            if (btn_sel) begin
               state_d = ST_SELECTED;
            end
         end

         // Priority is by button, so a higher-priority press that is ignored
         // (e.g. confirm when not full) still masks lower ones that cycle.
         ST_SELECTED: begin
            if (btn_sel) begin
               state_d = ST_IDLE;
            end else if (btn_confirm) begin
               if (fill_q == LEVEL_FULL) begin
                  state_d = ST_CONFIRMED;
               end
            end else if (btn_undo) begin
               if (fill_q != 3'd0) begin
                  layer_d[top_idx] = COL_EMPTY;
                  fill_d           = fill_q - 3'd1;
               end
            end else if (btn_pour) begin
               if (fill_q != LEVEL_FULL) begin
                  state_d    = ST_POURING;
                  pour_start = 1'b1;
               end
            end else if (btn_next) begin
               pend_d = next_colour(pend_q);
            end
         end

         ST_POURING: begin
            if (timer_done) begin
               layer_d[next_idx] = pend_q;
               fill_d            = fill_q + 3'd1;
               state_d           = ST_SELECTED;
            end
         end

         ST_CONFIRMED: begin
            if (btn_sel) begin
               for (int i = 0; i < MAX_LAYERS; i++) begin
                  layer_d[i] = COL_EMPTY;
               end
               fill_d  = 3'd0;
               pend_d  = COL_PINK;
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         fill_q      <= 3'd0;
         pend_q      <= COL_PINK;
         selected_q  <= 1'b0;
         confirmed_q <= 1'b0;
         busy_q      <= 1'b0;
         pour_done_q <= 1'b0;
         for (int i = 0; i < MAX_LAYERS; i++) begin
            layer_q[i] <= COL_EMPTY;
         end
      end else begin
         state_q     <= state_d;
         fill_q      <= fill_d;
         pend_q      <= pend_d;
         // Status flags are decoded from the next state so they line up with
         // the state register instead of lagging it by a cycle.
         selected_q  <= (state_d == ST_SELECTED) || (state_d == ST_POURING);
         confirmed_q <= (state_d == ST_CONFIRMED);
         busy_q      <= (state_d == ST_POURING);
         pour_done_q <= (state_q == ST_POURING) && timer_done;
         for (int i = 0; i < MAX_LAYERS; i++) begin
            layer_q[i] <= layer_d[i];
         end
      end
   end

   assign pending_colour = pend_q;
   assign colour1        = layer_q[0];
   assign colour2        = layer_q[1];
   assign colour3        = layer_q[2];
   assign colour4        = layer_q[3];
   assign fill_level     = fill_q;
   assign selected       = selected_q;
   assign confirmed      = confirmed_q;
   assign busy           = busy_q;
   assign pour_done      = pour_done_q;

endmodule

// File: tb/tb_boiler_fill_ctrl.sv
module tb_boiler_fill_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       frame_tick = 1'b0;
   logic       btn_sel = 1'b0;
   logic       btn_next = 1'b0;
   logic       btn_pour = 1'b0;
   logic       btn_undo = 1'b0;
   logic       btn_confirm = 1'b0;
   logic [2:0] pending_colour;
   logic [2:0] colour1, colour2, colour3, colour4;
   logic [2:0] fill_level;
   logic       selected, confirmed, busy, pour_done;

   int checks = 0;
   int errors = 0;

   boiler_fill_ctrl #(
      .FILL_TICKS (3)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .frame_tick     (frame_tick),
      .btn_sel        (btn_sel),
      .btn_next       (btn_next),
      .btn_pour       (btn_pour),
      .btn_undo       (btn_undo),
      .btn_confirm    (btn_confirm),
      .pending_colour (pending_colour),
      .colour1        (colour1),
      .colour2        (colour2),
      .colour3        (colour3),
      .colour4        (colour4),
      .fill_level     (fill_level),
      .selected       (selected),
      .confirmed      (confirmed),
      .busy           (busy),
      .pour_done      (pour_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_layers(input string tag, input int c1, input int c2,
                               input int c3, input int c4, input int lvl);
      check({tag, " colour1"}, 32'(colour1), 32'(c1));
      check({tag, " colour2"}, 32'(colour2), 32'(c2));
      check({tag, " colour3"}, 32'(colour3), 32'(c3));
      check({tag, " colour4"}, 32'(colour4), 32'(c4));
      check({tag, " fill_level"}, 32'(fill_level), 32'(lvl));
   endtask

   // One clock: inputs set before the call are seen at this edge, then all
   // pulses are dropped and outputs are sampled 1 time unit after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
      frame_tick  = 1'b0;
      btn_sel     = 1'b0;
      btn_next    = 1'b0;
      btn_pour    = 1'b0;
      btn_undo    = 1'b0;
      btn_confirm = 1'b0;
   endtask

   // Full pour with FILL_TICKS = 3, idle cycle between frame ticks.
   task automatic do_pour(input string tag, input int lvl_after);
      btn_pour = 1'b1;
      cyc();
      check({tag, " busy at start"}, 32'(busy), 32'd1);
      for (int k = 0; k < 3; k++) begin
         cyc();
         frame_tick = 1'b1;
         cyc();
      end
      check({tag, " busy after"}, 32'(busy), 32'd0);
      check({tag, " pour_done"}, 32'(pour_done), 32'd1);
      check({tag, " level"}, 32'(fill_level), 32'(lvl_after));
      cyc();
      check({tag, " pour_done drop"}, 32'(pour_done), 32'd0);
   endtask

   initial begin
      // Reset
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
      check("rst selected", 32'(selected), 32'd0);
      check("rst confirmed", 32'(confirmed), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst pour_done", 32'(pour_done), 32'd0);
      check("rst pending", 32'(pending_colour), 32'd1);
      check_layers("rst", 0, 0, 0, 0, 0);

      // IDLE ignores next
      btn_next = 1'b1; cyc();
      check("idle next ignored", 32'(pending_colour), 32'd1);
      check("idle still unselected", 32'(selected), 32'd0);

      // Test 1: select, next x2
      btn_sel = 1'b1; cyc();
      check("t1 selected", 32'(selected), 32'd1);
      btn_next = 1'b1; cyc();
      btn_next = 1'b1; cyc();
      check("t1 pending", 32'(pending_colour), 32'd3);
      check_layers("t1", 0, 0, 0, 0, 0);

      // Test 2: pour with 3 frame ticks; next/undo during pour have no effect
      btn_pour = 1'b1; cyc();
      check("t2 busy entry", 32'(busy), 32'd1);
      check("t2 selected while pouring", 32'(selected), 32'd1);
      frame_tick = 1'b1; cyc();
      check("t2 busy tick1", 32'(busy), 32'd1);
      check("t2 no done tick1", 32'(pour_done), 32'd0);
      btn_next = 1'b1; btn_undo = 1'b1; cyc();
      check("t5 next during pour", 32'(pending_colour), 32'd3);
      check("t5 undo during pour", 32'(fill_level), 32'd0);
      frame_tick = 1'b1; cyc();
      check("t2 busy tick2", 32'(busy), 32'd1);
      check("t2 no done tick2", 32'(pour_done), 32'd0);
      check("t2 colour1 before end", 32'(colour1), 32'd0);
      cyc();
      frame_tick = 1'b1; cyc();
      check("t2 busy tick3", 32'(busy), 32'd0);
      check("t2 pour_done", 32'(pour_done), 32'd1);
      check_layers("t2", 3, 0, 0, 0, 1);
      check("t2 pending kept", 32'(pending_colour), 32'd3);
      cyc();
      check("t2 pour_done one cycle", 32'(pour_done), 32'd0);

      // Empty again, walk pending 3 -> 4,5,6 -> wrap to 1
      btn_undo = 1'b1; cyc();
      check_layers("undo to 0", 0, 0, 0, 0, 0);
      btn_next = 1'b1; cyc();
      btn_next = 1'b1; cyc();
      btn_next = 1'b1; cyc();
      check("t5 pending 6", 32'(pending_colour), 32'd6);
      btn_next = 1'b1; cyc();
      check("t5 wrap to 1", 32'(pending_colour), 32'd1);

      // Test 4: undo at level 2, then undo+pour together
      do_pour("p1a", 1);
      btn_sel = 1'b1; cyc();
      check("deselect", 32'(selected), 32'd0);
      check("deselect keeps layer", 32'(colour1), 32'd1);
      btn_sel = 1'b1; cyc();
      btn_next = 1'b1; cyc();
      do_pour("p2a", 2);
      check_layers("t4 level2", 1, 2, 0, 0, 2);
      btn_undo = 1'b1; cyc();
      check_layers("t4 undo", 1, 0, 0, 0, 1);
      btn_undo = 1'b1; btn_pour = 1'b1; cyc();
      check("t4 undo+pour busy", 32'(busy), 32'd0);
      check_layers("t4 undo+pour", 0, 0, 0, 0, 0);

      // Test 3: four pours with pending 1..4 (pending is 2; five nexts -> 1)
      for (int k = 0; k < 5; k++) begin
         btn_next = 1'b1; cyc();
      end
      check("t3 pending 1", 32'(pending_colour), 32'd1);
      do_pour("p1", 1);
      btn_next = 1'b1; cyc();
      do_pour("p2", 2);
      btn_next = 1'b1; cyc();
      do_pour("p3", 3);
      btn_next = 1'b1; cyc();
      do_pour("p4", 4);
      check_layers("t3 full", 1, 2, 3, 4, 4);
      btn_pour = 1'b1; cyc();
      check("t3 5th pour busy", 32'(busy), 32'd0);
      check("t3 5th pour level", 32'(fill_level), 32'd4);
      btn_confirm = 1'b1; cyc();
      check("t3 confirmed", 32'(confirmed), 32'd1);
      check("t3 selected low", 32'(selected), 32'd0);
      btn_undo = 1'b1; cyc();
      check("confirmed ignores undo", 32'(fill_level), 32'd4);

      // Test 6b: CONFIRMED + sel clears everything
      btn_sel = 1'b1; cyc();
      check("t6 confirmed low", 32'(confirmed), 32'd0);
      check("t6 selected low", 32'(selected), 32'd0);
      check("t6 pending reset", 32'(pending_colour), 32'd1);
      check_layers("t6 cleared", 0, 0, 0, 0, 0);

      // Test 6a: reset on the 2nd tick of a pour
      btn_sel = 1'b1; cyc();
      btn_next = 1'b1; cyc();
      btn_pour = 1'b1; cyc();
      frame_tick = 1'b1; cyc();
      cyc();
      frame_tick = 1'b1; reset = 1'b1; cyc();
      reset = 1'b0;
      check("t6 rst busy", 32'(busy), 32'd0);
      check("t6 rst selected", 32'(selected), 32'd0);
      check("t6 rst pour_done", 32'(pour_done), 32'd0);
      check("t6 rst pending", 32'(pending_colour), 32'd1);
      check_layers("t6 rst", 0, 0, 0, 0, 0);
      frame_tick = 1'b1; cyc();
      frame_tick = 1'b1; cyc();
      check("t6 no late pour_done", 32'(pour_done), 32'd0);
      check("t6 no late layer", 32'(colour1), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
